// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator push-button front end.
package calc_pkg;

  typedef enum logic [1:0] {
    S2_IDLE      = 2'd0,
    S2_TIMING    = 2'd1,
    S2_LONG_HELD = 2'd2
  } s2_state_e;

  // Debug view: classifier state plus the release strobes of S0/S2/S3.
  typedef struct packed {
    s2_state_e  s2_state;
    logic [2:0] release_evt;
  } key_dbg_t;

  localparam int DEF_DB_SAMPLES = 3;
  localparam int DEF_LONG_TICKS = 100;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: polarity normalisation, 2-flop synchroniser, debouncer
// and registered press/release strobes (high in the cycle stable changes).
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DB_SAMPLES  = DEF_DB_SAMPLES,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk_db,
  input  logic rst,
  input  logic raw_i,
  output logic press_o,
  output logic release_o
);

  localparam int CW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);

  logic          norm;
  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  assign norm = ACTIVE_HIGH ? raw_i : ~raw_i;

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_db or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= norm;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/calc_key_events.sv
// Turns raw S0/S2/S3 buttons into one-cycle calculator events; S2 is
// classified as short or long by hold time.
module calc_key_events
  import calc_pkg::*;
#(
  parameter int DB_SAMPLES  = DEF_DB_SAMPLES,
  parameter int LONG_TICKS  = DEF_LONG_TICKS,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic     clk_db,
  input  logic     rst,
  input  logic     btn_s0_raw,
  input  logic     btn_s2_raw,
  input  logic     btn_s3_raw,
  output logic     btn_left,
  output logic     btn_right,
  output logic     s2_short,
  output logic     s2_long,
  output logic     s2_held,
  output key_dbg_t dbg
);

  localparam int HW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  logic [2:0] raw, press, rel;
  s2_state_e  state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic btn_left_q, btn_right_q, s2_short_q, s2_long_q, s2_held_q;
  logic s2_short_d, s2_long_d, s2_held_d;

  assign raw = {btn_s3_raw, btn_s2_raw, btn_s0_raw};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce #(.DB_SAMPLES(DB_SAMPLES), .ACTIVE_HIGH(ACTIVE_HIGH)) u_db (
      .clk_db    (clk_db),
      .rst       (rst),
      .raw_i     (raw[g]),
      .press_o   (press[g]),
      .release_o (rel[g])
    );
  end

  always_ff @(posedge clk_db or posedge rst) begin
    if (rst) begin
      state_q     <= S2_IDLE;
      hold_q      <= '0;
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      s2_short_q  <= 1'b0;
      s2_long_q   <= 1'b0;
      s2_held_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      btn_left_q  <= press[0];
      btn_right_q <= press[2];
      s2_short_q  <= s2_short_d;
      s2_long_q   <= s2_long_d;
      s2_held_q   <= s2_held_d;
    end
  end

  // Release is checked before the threshold so a tie counts as short.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S2_IDLE: begin
        if (press[1]) begin
          state_d = S2_TIMING;
          hold_d  = '0;
        end
      end
      S2_TIMING: begin
        if (rel[1])                 state_d = S2_IDLE;
        else if (hold_q == HOLD_LAST) state_d = S2_LONG_HELD;
        else                        hold_d  = hold_q + 1'b1;
      end
      S2_LONG_HELD: begin
        if (rel[1]) state_d = S2_IDLE;
      end
      default: state_d = S2_IDLE;
    endcase
  end

  always_comb begin
    s2_short_d = (state_q == S2_TIMING) && rel[1];
    s2_long_d  = (state_q == S2_TIMING) && !rel[1] && (hold_q == HOLD_LAST);
    s2_held_d  = s2_held_q;
    if (press[1])    s2_held_d = 1'b1;
    else if (rel[1]) s2_held_d = 1'b0;
  end

  assign btn_left  = btn_left_q;
  assign btn_right = btn_right_q;
  assign s2_short  = s2_short_q;
  assign s2_long   = s2_long_q;
  assign s2_held   = s2_held_q;
  assign dbg       = '{s2_state: state_q, release_evt: rel};

endmodule
